// File: rtl/pipe_pkg.sv
// Shared types and payload layout for the core's pipeline-stage registers.
// Every stage instance packs and unpacks its payload using these widths.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

  localparam int PC_W      = 32;
  localparam int REG_IDX_W = 5;

  // Payload layout, LSB first: PC, PC+4, data1, data2, rs1, rs2, rd.
  localparam int PC_OFF     = 0;
  localparam int PC4_OFF    = PC_OFF + PC_W;
  localparam int D1_OFF     = PC4_OFF + PC_W;
  localparam int D2_OFF     = D1_OFF + PC_W;
  localparam int RS1_OFF    = D2_OFF + PC_W;
  localparam int RS2_OFF    = RS1_OFF + REG_IDX_W;
  localparam int RD_OFF     = RS2_OFF + REG_IDX_W;
  localparam int PAYLOAD_W  = RD_OFF + REG_IDX_W;

  function automatic logic [1:0] occ_of(input stage_state_t s);
    case (s)
      BUSY:    return 2'd1;
      FULL:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             count_q <= '0;
    else if (inc && (count_q != {W{1'b1}})) count_q <= count_q + 1'b1;
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline-stage register with valid/ready handshake, optional 2-entry skid
// buffer, dual-source flush and a saturating count of flushes that lost data.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W     = PAYLOAD_W,
  parameter int SKID       = 1,
  parameter int FLUSH_ZERO = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_ctrl,
  input  logic              flush_hazard,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  flush_count
);

  stage_state_t      state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              flush, accept, emit;

  assign flush  = flush_ctrl | flush_hazard;
  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      if (FLUSH_ZERO != 0) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          state_d = BUSY;
          main_d  = in_data;
        end
        BUSY: begin
          if (accept && emit) begin
            main_d = in_data;
          end else if (accept) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (emit) begin
            state_d = EMPTY;
            if (FLUSH_ZERO != 0) main_d = '0;
          end
        end
        FULL: if (emit) begin
          state_d = BUSY;
          main_d  = skid_q;
          if (FLUSH_ZERO != 0) skid_d = '0;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // With SKID the ready is a pure state decode, breaking the out_ready path.
  always_comb begin
    out_valid = (state_q != EMPTY);
    occupancy = occ_of(state_q);
    if (SKID != 0) in_ready = !reset && (state_q != FULL);
    else           in_ready = !reset && (!out_valid || out_ready);
  end

  assign out_data = main_q;

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush && (out_valid || accept)),
    .count (flush_count)
  );

endmodule
